crc_engine_p: RTL and testbench



---
 rtl/crc_engine_p.sv | 182 ++++++++++++++++++
 tb/tb_crc_engine_p.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine_p.sv
// Bit-serial CRC peripheral (BPC bits per clock) on a Sel/RW register bus.
// Optional XOROUT register at +0x10 when CRC_FINAL_XOR_REG_EN is defined.
module crc_engine_p #(
    parameter int          CRC_W     = 32,
    parameter int          BPC       = 1,
    parameter logic [31:0] BASE_ADDR = 32'h4003_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Sel,
    input  logic        RW,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    input  logic [1:0]  size,
    output logic        ready,
    output logic [31:0] data_rd,
    output logic        busy,
    output logic        done_irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int               SH     = $clog2(BPC);
    localparam logic [CRC_W-1:0] FULL_M = '1;
    localparam logic [CRC_W-1:0] HALF_M = FULL_M >> (CRC_W / 2);

    state_t           state, nstate;
    logic [CRC_W-1:0] chk, work, step_chk;
    logic [31:0]      sh, poly, din_t, lane, chk32, act32, xor32;
    logic [5:0]       cnt, nbits, cnt_load;
    logic             tcrc, was, fxor, done_flag;
    logic [1:0]       totr, tot;
    logic             hit_data, hit_poly, hit_ctrl, hit_stat, hit_xor;
    logic             wr_acc, seed_wr, comp_wr;
`ifdef CRC_FINAL_XOR_REG_EN
    logic [31:0]      xorout;
`endif

    function automatic logic [31:0] xpose(input logic [31:0] d, input logic [1:0] mode);
        logic [31:0] r;
        r = d;
        case (mode)
            2'b01: for (int i = 0; i < 32; i++) r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
            2'b10: for (int i = 0; i < 32; i++) r[i] = d[31 - i];
            2'b11: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] crc_bit(input logic [CRC_W-1:0] c, input logic b,
                                                 input logic [CRC_W-1:0] p, input logic full);
        logic [CRC_W-1:0] msk;
        logic             top;
        logic [CRC_W-1:0] r;
        msk = full ? FULL_M : HALF_M;
        top = full ? c[CRC_W-1] : c[CRC_W/2-1];
        r   = {c[CRC_W-2:0], b} & msk;
        if (top) r = r ^ (p & msk);
        return r;
    endfunction

    assign hit_data = (addr == BASE_ADDR);
    assign hit_poly = (addr == BASE_ADDR + 32'h4);
    assign hit_ctrl = (addr == BASE_ADDR + 32'h8);
    assign hit_stat = (addr == BASE_ADDR + 32'hC);
    assign hit_xor  = (addr == BASE_ADDR + 32'h10);

    assign ready   = (state != RUN);
    assign wr_acc  = Sel && RW && ready;
    assign seed_wr = wr_acc && hit_data && was;
    assign comp_wr = wr_acc && hit_data && !was;

    assign din_t = xpose(data_wr, tot);

    always_comb begin
        lane  = din_t;
        nbits = 6'd32;
        case (size)
            2'b00:   begin lane = {din_t[7:0], 24'h0};  nbits = 6'd8;  end
            2'b01:   begin lane = {din_t[15:0], 16'h0}; nbits = 6'd16; end
            default: ;
        endcase
    end
    assign cnt_load = (nbits >> SH) - 6'd1;

    // BPC bits are folded in MSB-first within a single cycle.
    always_comb begin
        step_chk = work;
        for (int i = 0; i < BPC; i++)
            step_chk = crc_bit(step_chk, sh[31-i], poly[CRC_W-1:0], tcrc);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate   = state;
        busy     = 1'b0;
        done_irq = 1'b0;
        case (state)
            IDLE: if (comp_wr) nstate = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == 6'd0) nstate = DONE;
            end
            DONE: begin
                done_irq = 1'b1;
                nstate   = comp_wr ? RUN : IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk       <= FULL_M;
            work      <= '0;
            sh        <= '0;
            cnt       <= '0;
            poly      <= 32'h0000_1021;
            tcrc      <= 1'b0;
            was       <= 1'b0;
            fxor      <= 1'b0;
            totr      <= 2'b00;
            tot       <= 2'b00;
            done_flag <= 1'b0;
`ifdef CRC_FINAL_XOR_REG_EN
            xorout    <= '1;
`endif
        end else begin
            if (wr_acc && hit_poly) poly <= data_wr;
            if (wr_acc && hit_ctrl) begin
                tcrc <= data_wr[24];
                was  <= data_wr[25];
                fxor <= data_wr[26];
                totr <= data_wr[29:28];
                tot  <= data_wr[31:30];
            end
`ifdef CRC_FINAL_XOR_REG_EN
            if (wr_acc && hit_xor) xorout <= data_wr;
`endif
            if (seed_wr) chk <= din_t[CRC_W-1:0];
            // Work copy keeps DATA reads at the pre-operation value until commit.
            if (comp_wr) begin
                work <= chk;
                sh   <= lane;
                cnt  <= cnt_load;
            end else if (state == RUN) begin
                work <= step_chk;
                sh   <= sh << BPC;
                cnt  <= cnt - 6'd1;
                if (cnt == 6'd0) chk <= step_chk;
            end
            if (state == DONE)                           done_flag <= 1'b1;
            else if (wr_acc && hit_stat && data_wr[1])   done_flag <= 1'b0;
        end
    end

    always_comb begin
        chk32 = '0;
        chk32[CRC_W-1:0] = chk;
        act32 = '0;
        act32[CRC_W-1:0] = tcrc ? FULL_M : HALF_M;
`ifdef CRC_FINAL_XOR_REG_EN
        xor32 = xorout & act32;
`else
        xor32 = act32;
`endif
        data_rd = '0;
        if (Sel && !RW) begin
            if (hit_data)      data_rd = xpose(fxor ? (chk32 ^ xor32) : chk32, totr);
            else if (hit_poly) data_rd = poly;
            else if (hit_ctrl) data_rd = {tot, totr, 1'b0, fxor, was, tcrc, 24'h0};
            else if (hit_stat) data_rd = {30'h0, done_flag, busy};
`ifdef CRC_FINAL_XOR_REG_EN
            else if (hit_xor)  data_rd = xorout;
`endif
        end
    end
endmodule

// File: tb/tb_crc_engine_p.sv
// Bench for crc_engine_p: vector table, hand sequences and randomized writes vs. a model.
module tb_crc_engine_p;
    localparam int          P_BPC = 1;
    localparam logic [31:0] BASE  = 32'h4003_2000;

    logic        clk, rst, Sel, RW, ready, busy, done_irq;
    logic [31:0] addr, data_wr, data_rd;
    logic [1:0]  size;

    crc_engine_p #(.CRC_W(32), .BPC(P_BPC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .Sel(Sel), .RW(RW), .addr(addr), .data_wr(data_wr),
        .size(size), .ready(ready), .data_rd(data_rd), .busy(busy), .done_irq(done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int irq_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (done_irq) irq_cnt++;
        if (busy) busy_cnt++;
    end

    // Reference state
    logic [31:0] m_chk, m_next, m_poly, m_ctrl, m_xor;
    logic        m_done;

    typedef struct {
        logic [31:0] cs, seed, cr, poly, d;
        logic [1:0]  sz;
        logic [31:0] crd, exp;
        int          cyc;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] tr(input logic [31:0] d, input logic [1:0] mode);
        logic [31:0] r;
        logic [7:0]  y;
        r = d;
        if (mode == 2'b01) begin
            for (int b = 0; b < 4; b++) begin
                y = d[8*b +: 8];
                r[8*b +: 8] = {<<{y}};
            end
        end else if (mode == 2'b10) r = {<<{d}};
        else if (mode == 2'b11)     r = {<<8{d}};
        return r;
    endfunction

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    endfunction

    function automatic logic [31:0] mdl_crc(input logic [31:0] c0, input logic [31:0] p,
                                            input logic [31:0] d, input logic [1:0] sz,
                                            input logic [31:0] ctl);
        logic [31:0] c, x, msk;
        int          w;
        logic        m;
        c   = c0;
        w   = ctl[24] ? 32 : 16;
        msk = ctl[24] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        x   = tr(d, ctl[31:30]);
        for (int i = nb(sz) - 1; i >= 0; i--) begin
            m = c[w-1];
            c = ((c << 1) | {31'h0, x[i]}) & msk;
            if (m) c = c ^ (p & msk);
        end
        return c;
    endfunction

    function automatic logic [31:0] model_rd();
        logic [31:0] v, am;
        am = m_ctrl[24] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        v  = m_chk;
`ifdef CRC_FINAL_XOR_REG_EN
        if (m_ctrl[26]) v = v ^ (m_xor & am);
`else
        if (m_ctrl[26]) v = v ^ am;
`endif
        return tr(v, m_ctrl[29:28]);
    endfunction

    task automatic model_reset();
        m_chk = 32'hFFFF_FFFF; m_next = m_chk; m_poly = 32'h1021;
        m_ctrl = 0; m_done = 1'b0; m_xor = 32'hFFFF_FFFF;
    endtask

    task automatic model_write(input logic [31:0] off, input logic [31:0] d, input logic [1:0] sz);
        case (off)
            32'h0:  if (m_ctrl[25]) m_chk = tr(d, m_ctrl[31:30]);
                    else m_next = mdl_crc(m_chk, m_poly, d, sz, m_ctrl);
            32'h4:  m_poly = d;
            32'h8:  m_ctrl = d;
            32'hC:  if (d[1]) m_done = 1'b0;
            32'h10: m_xor = d;
            default: ;
        endcase
    endtask

    task automatic commit();
        m_chk  = m_next;
        m_done = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [1:0] sz);
        int g;
        g = 0;
        Sel = 1'b1; RW = 1'b1; addr = BASE + off; data_wr = d; size = sz;
        #1;
        while (!ready && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        if (!ready) begin
            vecs++; errs++;
            $display("FAIL write_timeout: got ready=0 expected ready=1 at off %h", off);
        end
        @(posedge clk); #1;
        model_write(off, d, sz);
        Sel = 1'b0; RW = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] v);
        Sel = 1'b1; RW = 1'b0; addr = BASE + off;
        #1;
        v = data_rd;
        Sel = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int   n, g;
        logic seen;
        n = 0; g = 0; seen = 1'b0;
        while (g < 300) begin
            #1;
            if (done_irq) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            @(negedge clk);
            g++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(n), 32'(exp_cyc));
        @(negedge clk); #1;
        chk("irq_single", 32'(done_irq), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        commit();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, c, d;
        logic [1:0]  sz;
        int          b0, i0;

        tbl[0] = '{32'h0300_0000, 32'h0, 32'h0100_0000, 32'h04C1_1DB7, 32'h1, 2'b10, 32'h0100_0000, 32'h0000_0001, 32};
        tbl[1] = '{32'h0200_0000, 32'h8000, 32'h0, 32'h1021, 32'hAB00, 2'b00, 32'h0, 32'h0000_9188, 8};
        tbl[2] = '{32'h0200_0000, 32'h8000, 32'h0, 32'h1021, 32'hAB00, 2'b00, 32'h0400_0000, 32'h0000_6E77, 8};
        tbl[3] = '{32'h0200_0000, 32'h0, 32'h0, 32'h1021, 32'h80, 2'b00, 32'h0, 32'h0000_0080, 8};
        tbl[4] = '{32'h0200_0000, 32'h0, 32'h0, 32'h1021, 32'h80, 2'b00, 32'h3000_0000, 32'h8000_0000, 8};
        tbl[5] = '{32'h0200_0000, 32'h0, 32'h0, 32'h1021, 32'h1234, 2'b01, 32'h0, 32'h0000_1234, 16};
        tbl[6] = '{32'h0200_0000, 32'h0, 32'h4000_0000, 32'h1021, 32'h12, 2'b00, 32'h4000_0000, 32'h0000_0048, 8};
        tbl[7] = '{32'h0200_0000, 32'h0, 32'hA000_0000, 32'h1021, 32'h0100_0000, 2'b10, 32'hA000_0000, 32'h0100_0000, 32};

        rst = 1'b1; Sel = 1'b0; RW = 1'b0; addr = 0; data_wr = 0; size = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_irq", 32'(done_irq), 32'd0);
        bus_read(32'h0, r);  chk("rst_data", r, 32'hFFFF_FFFF);
        bus_read(32'h4, r);  chk("rst_gpoly", r, 32'h0000_1021);
        bus_read(32'h8, r);  chk("rst_ctrl", r, 32'h0);
        bus_read(32'hC, r);  chk("rst_status", r, 32'h0);
`ifdef CRC_FINAL_XOR_REG_EN
        bus_read(32'h10, r); chk("rst_xorout", r, 32'hFFFF_FFFF);
`else
        bus_read(32'h10, r); chk("unmapped_10", r, 32'h0);
`endif
        bus_read(32'h14, r); chk("unmapped_14", r, 32'h0);
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            bus_write(32'h8, tbl[k].cs, 2'b10);
            bus_write(32'h0, tbl[k].seed, 2'b10);
            bus_write(32'h8, tbl[k].cr, 2'b10);
            bus_write(32'h4, tbl[k].poly, 2'b10);
            bus_write(32'h0, tbl[k].d, tbl[k].sz);
            wait_done(tbl[k].cyc / P_BPC);
            bus_write(32'h8, tbl[k].crd, 2'b10);
            bus_read(32'h0, r);
            chk($sformatf("tbl%0d_data", k), r, tbl[k].exp);
            @(negedge clk);
        end

        // Write during busy must stall and land in the DONE cycle.
        bus_write(32'h8, 32'h0300_0000, 2'b10);
        bus_write(32'h0, 32'h0, 2'b10);
        bus_write(32'h8, 32'h0100_0000, 2'b10);
        bus_write(32'h4, 32'h04C1_1DB7, 2'b10);
        b0 = busy_cnt; i0 = irq_cnt;
        bus_write(32'h0, 32'h1, 2'b10);
        #1;
        chk("stall_ready", 32'(ready), 32'd0);
        bus_write(32'h4, 32'h1234_5678, 2'b10);
        commit();
        repeat (3) @(negedge clk);
        chk("stall_busy_len", 32'(busy_cnt - b0), 32'(32 / P_BPC));
        chk("stall_irq_cnt", 32'(irq_cnt - i0), 32'd1);
        bus_read(32'h4, r); chk("stall_gpoly", r, 32'h1234_5678);
        bus_read(32'h0, r); chk("stall_data", r, 32'h0000_0001);
        @(negedge clk);

        // Reset in the middle of a computation.
        bus_write(32'h0, 32'hDEAD_BEEF, 2'b10);
        repeat (5) @(negedge clk);
        i0 = irq_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_irq", 32'(done_irq), 32'd0);
        bus_read(32'h0, r); chk("abort_data", r, 32'hFFFF_FFFF);
        repeat (40) @(negedge clk);
        chk("abort_no_irq", 32'(irq_cnt - i0), 32'd0);

        // Sticky done, clear coinciding with DONE (set wins), then a real clear.
        bus_write(32'h0, 32'h5A, 2'b00);
        wait_done(8 / P_BPC);
        bus_read(32'hC, r); chk("status_done", r, 32'h2);
        bus_write(32'h0, 32'hC3, 2'b00);
        bus_read(32'hC, r); chk("status_busy", r, 32'h3);
        bus_read(32'h0, r); chk("data_preop", r, model_rd());
        bus_write(32'hC, 32'h2, 2'b10);
        commit();
        bus_read(32'hC, r); chk("status_setwins", r, 32'h2);
        bus_read(32'h0, r); chk("data_postop", r, model_rd());
        bus_write(32'hC, 32'h2, 2'b10);
        bus_read(32'hC, r); chk("status_clear", r, 32'h0);
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            c  = $urandom & 32'hF700_0000;
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            bus_write(32'h8, c, 2'b10);
            if ($urandom_range(0, 1) == 1) bus_write(32'h4, $urandom, 2'b10);
            bus_write(32'h0, d, sz);
            if (!c[25]) wait_done(nb(sz) / P_BPC);
            else begin
                #1;
                chk("seed_no_busy", 32'(busy), 32'd0);
            end
            bus_read(32'h0, r); chk("rand_data", r, model_rd());
            bus_read(32'h8, r); chk("rand_ctrl", r, m_ctrl & 32'hF700_0000);
            bus_read(32'h4, r); chk("rand_gpoly", r, m_poly);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
